uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_frame_tx.sv | 152 +++++++++++++++
 tb/tb_uart_frame_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART frame transmitter: parity selection and FSM state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Wide enough to index up to 9 data bits or 2 stop bits.
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter with a one-word holding register ahead of the shifter,
// allowing back-to-back frames without an idle gap.
//
// state     | meaning
// ----------+--------------------------------------------
// ST_IDLE   | line idle high, waiting for a word
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting data bits out, LSB first
// ST_PARITY | driving the parity bit (skipped for PAR_NONE)
// ST_STOP   | driving STOP_BITS stop bits (1)
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int      DATA_W       = 8,
  parameter int      CLKS_PER_BIT = 100,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e             r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_shift, w_shift_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_par, w_par_nxt;
  logic [DATA_W-1:0]     r_hold;
  logic                  r_hold_full, w_hold_full_nxt;
  logic                  r_ready;
  logic                  r_txd, w_txd_nxt;
  logic                  w_tick;
  logic                  w_accept, w_last, w_load, w_load_direct, w_to_hold;
  logic [DATA_W-1:0]     w_load_word;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_load),
    .tick (w_tick)
  );

  // A word goes straight to the shifter when the line is free (idle, or the last
  // stop bit ends with nothing held); otherwise it waits in the hold register.
  assign w_accept      = tx_valid & r_ready;
  assign w_last        = (r_state == ST_STOP) && w_tick && (r_bit_cnt == STOP_LAST);
  assign w_load_direct = w_accept && ((r_state == ST_IDLE) || (w_last && !r_hold_full));
  assign w_load        = w_load_direct || (w_last && r_hold_full);
  assign w_to_hold     = w_accept && !w_load_direct;
  assign w_load_word   = r_hold_full ? r_hold : tx_data;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_nxt     = r_par;
    case (r_state)
      ST_IDLE: begin
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_cnt_nxt = '0;
            if (PARITY == PAR_NONE) w_state_nxt = ST_STOP;
            else                    w_state_nxt = ST_PARITY;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt   = ST_STOP;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == STOP_LAST) w_state_nxt = ST_IDLE;
          else                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt   = ST_START;
      w_shift_nxt   = w_load_word;
      w_bit_cnt_nxt = '0;
      w_par_nxt     = (PARITY == PAR_ODD) ? ~^w_load_word : ^w_load_word;
    end

    // txd is registered from the next state so the line never glitches.
    case (w_state_nxt)
      ST_START:  w_txd_nxt = 1'b0;
      ST_DATA:   w_txd_nxt = w_shift_nxt[0];
      ST_PARITY: w_txd_nxt = w_par_nxt;
      default:   w_txd_nxt = 1'b1;
    endcase
  end

  always_comb begin
    w_hold_full_nxt = r_hold_full;
    if (w_load && r_hold_full) w_hold_full_nxt = 1'b0;
    else if (w_to_hold)        w_hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par       <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b0;
      r_txd       <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_par       <= w_par_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_ready     <= ~w_hold_full_nxt;
      r_txd       <= w_txd_nxt;
      if (w_to_hold) r_hold <= tx_data;
    end
  end

  assign tx_ready   = r_ready;
  assign txd        = r_txd;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = w_last;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three parameter sets driven from one process, each with a
// per-cycle expected-waveform queue filled on accept and drained every cycle.
module tb_uart_frame_tx;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int NI  = 3;

  typedef struct packed { logic txd; logic done; } cyc_t;
  typedef struct { int inst; logic [7:0] data; int exp_bits; int exp_cycles; } vec_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    tx_data [NI];
  logic [NI-1:0] tx_valid;
  logic [NI-1:0] tx_ready, txd, busy, frame_done;

  always #5 clk = ~clk;

  // 0: 8N1   1: 8E1   2: 7O2
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int      DW = (g == 2) ? 7 : 8;
    localparam parity_e PM = (g == 0) ? PAR_NONE : ((g == 1) ? PAR_EVEN : PAR_ODD);
    localparam int      SB = (g == 2) ? 2 : 1;
    uart_frame_tx #(
      .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY(PM), .STOP_BITS(SB)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[g][DW-1:0]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .txd(txd[g]), .busy(busy[g]), .frame_done(frame_done[g])
    );
  end

  function automatic int dw_of(int i);   return (i == 2) ? 7 : 8; endfunction
  function automatic int par_of(int i);  return (i == 0) ? 0 : ((i == 1) ? 1 : 2); endfunction
  function automatic int stop_of(int i); return (i == 2) ? 2 : 1; endfunction
  function automatic int flen(int i);
    return CPB * (1 + dw_of(i) + ((par_of(i) != 0) ? 1 : 0) + stop_of(i));
  endfunction

  cyc_t          q [NI][$];
  logic          rst_prev = 1'b1;
  logic [NI-1:0] obs_txd, obs_busy, obs_done, obs_ready, acc;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;

  task automatic push_frame(input int i, input logic [7:0] d);
    logic fb [$];
    logic p;
    cyc_t e;
    p = 1'b0;
    fb.push_back(1'b0);
    for (int b = 0; b < dw_of(i); b++) begin
      fb.push_back(d[b]);
      p ^= d[b];
    end
    if (par_of(i) == 1) fb.push_back(p);
    else if (par_of(i) == 2) fb.push_back(~p);
    for (int s = 0; s < stop_of(i); s++) fb.push_back(1'b1);
    for (int k = 0; k < fb.size(); k++) begin
      for (int c = 0; c < CPB; c++) begin
        e.txd  = fb[k];
        e.done = (k == fb.size() - 1) && (c == CPB - 1);
        q[i].push_back(e);
      end
    end
  endtask

  // One clock: compare at the falling edge, decide accepts for the coming rising edge,
  // then return just after that rising edge so stimulus can change.
  task automatic step();
    cyc_t       e;
    logic       busy_e, rdy;
    logic [3:0] exp_v, act_v;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      e.txd  = 1'b1;
      e.done = 1'b0;
      busy_e = (q[i].size() != 0);
      if (busy_e) e = q[i].pop_front();
      rdy   = !rst_prev && (q[i].size() < flen(i));
      exp_v = {e.txd, busy_e, e.done, rdy};
      act_v = {txd[i], busy[i], frame_done[i], tx_ready[i]};
      obs_txd[i]   = txd[i];
      obs_busy[i]  = busy[i];
      obs_done[i]  = frame_done[i];
      obs_ready[i] = tx_ready[i];
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle%0d inst%0d {txd,busy,frame_done,tx_ready}: got %b expected %b",
                 cyc, i, act_v, exp_v);
      end
      acc[i] = tx_valid[i] && rdy && rst_n;
      if (!rst_n) q[i].delete();
      else if (acc[i]) push_frame(i, tx_data[i]);
    end
    rst_prev = !rst_n;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle 1 is the first cycle after the accept edge.
  task automatic wait_frame(input int i, output int len, output int bits);
    len  = -1;
    bits = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if ((c % CPB) == 2) bits |= int'(obs_txd[i]) << ((c - 2) / CPB);
      if (obs_done[i]) begin
        len = c;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int   len, bits, d1, d2, s41, cnt, left;

    vecs[0] = '{0, 8'hA5, 'h34A, 40};
    vecs[1] = '{1, 8'h07, 'h60E, 44};
    vecs[2] = '{2, 8'h00, 'h700, 44};
    vecs[3] = '{1, 8'h03, 'h406, 44};
    vecs[4] = '{2, 8'h7F, 'h6FE, 44};
    vecs[5] = '{0, 8'hFF, 'h3FE, 40};
    vecs[6] = '{1, 8'h80, 'h700, 44};
    vecs[7] = '{2, 8'h15, 'h62A, 44};

    for (int i = 0; i < NI; i++) tx_data[i] = '0;
    tx_valid = '0;
    rst_n    = 1'b0;
    repeat (3) step();
    check("reset_txd",   int'(obs_txd[0]), 1);
    check("reset_busy",  int'(obs_busy[0]), 0);
    check("reset_done",  int'(obs_done[0]), 0);
    check("reset_ready", int'(obs_ready[0]), 0);
    rst_n = 1'b1;
    step();
    step();
    check("ready_after_release", int'(obs_ready[0]), 1);

    // Data wiggling without tx_valid must not start anything.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < NI; i++) tx_data[i] = 8'($urandom);
      step();
    end
    check("no_tx_without_accept", int'(obs_busy), 0);

    foreach (vecs[v]) begin
      int i;
      i = vecs[v].inst;
      tx_data[i]  = vecs[v].data;
      tx_valid[i] = 1'b1;
      step();
      tx_valid[i] = 1'b0;
      check($sformatf("vec%0d_accept", v), int'(acc[i]), 1);
      wait_frame(i, len, bits);
      check($sformatf("vec%0d_len", v), len, vecs[v].exp_cycles);
      check($sformatf("vec%0d_bits", v), bits, vecs[v].exp_bits);
      step();
      check($sformatf("vec%0d_busy_fell", v), int'(obs_busy[i]), 0);
    end

    // Back-to-back: 0x55 then 0xAA with tx_valid held.
    tx_data[0] = 8'h55; tx_valid[0] = 1'b1;
    step();
    check("b2b_acc1", int'(acc[0]), 1);
    tx_data[0] = 8'hAA;
    step();
    check("b2b_acc2", int'(acc[0]), 1);
    tx_valid[0] = 1'b0;
    step();
    check("b2b_ready_low", int'(obs_ready[0]), 0);
    d1 = -1; d2 = -1; s41 = -1;
    for (int c = 3; c <= 120 && d2 < 0; c++) begin
      step();
      if (c == 41) s41 = int'({obs_busy[0], obs_txd[0]});
      if (obs_done[0]) begin
        if (d1 < 0) d1 = c;
        else        d2 = c;
      end
    end
    check("b2b_done1_cycle", d1, 40);
    check("b2b_done_spacing", d2 - d1, 40);
    check("b2b_no_gap_start", s41, 2);
    step();

    // Accept in the very cycle the last stop bit ends, nothing held.
    tx_data[1] = 8'h11; tx_valid[1] = 1'b1;
    step();
    tx_valid[1] = 1'b0;
    for (int c = 1; c <= 43; c++) step();
    tx_data[1] = 8'h22; tx_valid[1] = 1'b1;
    step();
    tx_valid[1] = 1'b0;
    check("edge_done", int'(obs_done[1]), 1);
    check("edge_accept", int'(acc[1]), 1);
    step();
    check("edge_nogap_txd", int'(obs_txd[1]), 0);
    check("edge_nogap_busy", int'(obs_busy[1]), 1);
    wait_frame(1, len, bits);
    check("edge_frame2_len", len, 43);
    step();

    // Reset during the third data bit with a second word held.
    tx_data[0] = 8'h5A; tx_valid[0] = 1'b1;
    step();
    tx_data[0] = 8'h3C;
    step();
    check("rst_held_acc", int'(acc[0]), 1);
    tx_valid[0] = 1'b0;
    for (int c = 2; c <= 14; c++) step();
    rst_n = 1'b0;
    step();
    step();
    check("rst_txd", int'(obs_txd[0]), 1);
    check("rst_busy", int'(obs_busy[0]), 0);
    rst_n = 1'b1;
    step();
    check("rst_ready_still_low", int'(obs_ready[0]), 0);
    step();
    check("rst_ready_after_release", int'(obs_ready[0]), 1);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (obs_busy[0] || obs_done[0]) cnt++;
    end
    check("rst_held_word_dropped", cnt, 0);

    // Random traffic on all three instances.
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NI; i++) begin
        tx_data[i]  = 8'($urandom);
        tx_valid[i] = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    tx_valid = '0;
    left = 1;
    for (int k = 0; k < 200 && left != 0; k++) begin
      step();
      left = q[0].size() + q[1].size() + q[2].size();
    end
    step();
    check("drain_idle", int'(obs_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
